// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: circular FIFO over a dual-port BRAM (A write, B read) with a 2-entry output buffer.
// Define BRAM_FIFO_HWM_EN to build the occupancy high-water-mark register; otherwise hwm reads 0.
module bram_fifo_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W:0]   hwm,
  output logic [ADDR_W-1:0] bram_addr_a,
  output logic              bram_we_a,
  output logic [DATA_W-1:0] bram_din_a,
  output logic [ADDR_W-1:0] bram_addr_b,
  output logic              bram_we_b,
  input  logic [DATA_W-1:0] bram_dout_b
);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   mem_count_q, mem_count_d;
  logic              rd_pending_q, issue, pop;
  logic [1:0]        occ_q, occ_d, slot;
  logic [DATA_W-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  assign s_ready     = !rst && (mem_count_q != DEPTH);
  assign bram_we_a   = s_valid && s_ready;
  assign bram_addr_a = wr_ptr_q;
  assign bram_din_a  = s_data;
  assign bram_addr_b = rd_ptr_q;
  assign bram_we_b   = 1'b0;
  assign m_valid     = occ_q != 2'd0;
  assign m_data      = buf0_q;
  assign pop         = m_valid && m_ready;
  assign count       = mem_count_q + (ADDR_W+1)'(rd_pending_q) + (ADDR_W+1)'(occ_q);
  // Issue only if the buffer can still hold everything in flight after this cycle's pop.
  assign issue       = (mem_count_q != '0) && (({1'b0, occ_q} + 3'(rd_pending_q) - 3'(pop)) < 3'd2);
  assign slot        = occ_q - 2'(pop);
  always_comb begin
    wr_ptr_d    = wr_ptr_q + ADDR_W'(bram_we_a);
    rd_ptr_d    = rd_ptr_q + ADDR_W'(issue);
    mem_count_d = mem_count_q + (ADDR_W+1)'(bram_we_a) - (ADDR_W+1)'(issue);
    occ_d       = occ_q + 2'(rd_pending_q) - 2'(pop);
    // Head shifts forward on pop; when the buffer empties buf0 keeps the last sample.
    buf0_d      = (pop && occ_q == 2'd2) ? buf1_q : (rd_pending_q && slot == 2'd0) ? bram_dout_b : buf0_q;
    buf1_d      = (rd_pending_q && slot == 2'd1) ? bram_dout_b : buf1_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_count_q  <= '0;
      rd_pending_q <= 1'b0;
      occ_q        <= '0;
      buf0_q       <= '0;
      buf1_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_count_q  <= mem_count_d;
      rd_pending_q <= issue;
      occ_q        <= occ_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
    end
  end
`ifdef BRAM_FIFO_HWM_EN
  logic [ADDR_W:0] hwm_q;
  always_ff @(posedge clk) begin
    if (rst) hwm_q <= '0;
    else if (count > hwm_q) hwm_q <= count;
  end
  assign hwm = hwm_q;
`else
  assign hwm = '0;
`endif
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// tb_bram_fifo_ctrl: directed + random checks of bram_fifo_ctrl against a queue model of the FIFO.
module tb_bram_fifo_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  s_data = '0, m_data, bram_din_a, bram_dout_b = '0;
  logic        s_valid = 1'b0, s_ready, m_valid, m_ready = 1'b0, bram_we_a, bram_we_b;
  logic [10:0] count, hwm;
  logic [9:0]  bram_addr_a, bram_addr_b;
  logic [7:0]  mem [1024];
  logic [7:0]  q [$];
  int          n_assert = 0, n_fail = 0, hwm_m = 0;

  always #5 clk = ~clk;

  bram_fifo_ctrl dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .count(count), .hwm(hwm),
    .bram_addr_a(bram_addr_a), .bram_we_a(bram_we_a), .bram_din_a(bram_din_a),
    .bram_addr_b(bram_addr_b), .bram_we_b(bram_we_b), .bram_dout_b(bram_dout_b)
  );

  always @(posedge clk) begin
    if (bram_we_a) mem[bram_addr_a] <= bram_din_a;
    bram_dout_b <= mem[bram_addr_b];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic sv, input logic [7:0] sd, input logic mr, output logic acc);
    logic [7:0] e;
    s_valid = sv; s_data = sd; m_ready = mr;
    #1;
    chk("count", 32'(count), 32'(q.size()));
    chk("we_b", 32'(bram_we_b), 32'd0);
    if (q.size() == 0) chk("m_valid_empty", 32'(m_valid), 32'd0);
    if (m_valid && m_ready) begin
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("m_data", 32'(m_data), 32'(e));
      end
    end
    acc = s_valid && s_ready;
    if (acc) q.push_back(sd);
    if (q.size() > hwm_m) hwm_m = q.size();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    #1;
    chk("s_ready_in_rst", 32'(s_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    hwm_m = 0;
    #1;
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_hwm", 32'(hwm), 32'd0);
    chk("rst_we_a", 32'(bram_we_a), 32'd0);
    chk("rst_we_b", 32'(bram_we_b), 32'd0);
  endtask

  task automatic drain();
    logic a;
    for (int i = 0; i < 3000 && q.size() > 0; i++) cyc(1'b0, 8'h00, 1'b1, a);
    chk("drain_left", 32'(q.size()), 32'd0);
    chk("drain_count", 32'(count), 32'd0);
  endtask

  initial begin
    logic a, sv, mr;
    logic [7:0] d;
    int sent;
    @(negedge clk);
    do_reset();
    chk("rst_m_data", 32'(m_data), 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0, a);

    cyc(1'b1, 8'h7F, 1'b1, a);
    chk("lat_acc", 32'(a), 32'd1);
    chk("lat_mv_e0", 32'(m_valid), 32'd0);
    cyc(1'b0, 8'h00, 1'b1, a);
    chk("lat_mv_e1", 32'(m_valid), 32'd0);
    cyc(1'b0, 8'h00, 1'b1, a);
    chk("lat_mv_e2", 32'(m_valid), 32'd1);
    chk("lat_data", 32'(m_data), 32'h7F);
    cyc(1'b0, 8'h00, 1'b1, a);
    chk("lat_popped", 32'(count), 32'd0);
    chk("empty_hold", 32'(m_data), 32'h7F);

    do_reset();
    for (int i = 0; i < 1200 && q.size() < 1026; i++) cyc(1'b1, 8'(q.size()), 1'b0, a);
    s_valid = 1'b0;
    #1;
    chk("full_s_ready", 32'(s_ready), 32'd0);
    chk("full_count", 32'(count), 32'd1026);
    cyc(1'b0, 8'h00, 1'b0, a);
`ifdef BRAM_FIFO_HWM_EN
    chk("full_hwm", 32'(hwm), 32'(hwm_m));
`else
    chk("full_hwm", 32'(hwm), 32'd0);
`endif
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 8'($urandom), 1'b1, a);
      chk("full_band", 32'(count >= 11'd1025 && count <= 11'd1026), 32'd1);
    end
    drain();

    do_reset();
    sent = 0;
    for (int i = 0; i < 20000 && sent < 3000; i++) begin
      sv = 1'($urandom_range(0, 1));
      mr = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      if (i % 7 == 0) d = 8'h80;
      if (i % 11 == 0) d = 8'hFF;
      cyc(sv, d, mr, a);
      if (a) sent++;
    end
    chk("rand_sent", 32'(sent), 32'd3000);
    drain();

    do_reset();
    for (int i = 0; i < 600 && q.size() < 500; i++) cyc(1'b1, 8'($urandom), 1'b0, a);
    chk("mid_held", 32'(count), 32'd500);
    do_reset();
    cyc(1'b1, 8'h5A, 1'b0, a);
    cyc(1'b0, 8'h00, 1'b0, a);
    cyc(1'b0, 8'h00, 1'b0, a);
    chk("mid_mvalid", 32'(m_valid), 32'd1);
    chk("mid_first", 32'(m_data), 32'h5A);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
